// File: rtl/stack_row_engine.sv
// stack_row_engine: game engine for the 8x8 stacking display.
// A block segment slides across the current row. Each button press commits
// the overlap with the row below, and the engine detects a win or a loss.
// Every output is a register. An action taken while leaving a state becomes
// visible in the cycle after that state.
module stack_row_engine #(
   parameter int unsigned INIT_WIDTH = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn,
   input  logic       update_tick,
   output logic [7:0] val,
   output logic [2:0] row_index,
   output logic       write_strobe,
   output logic       clr_array,
   output logic       game_over,
   output logic       win,
   output logic [3:0] rows_placed
);

   typedef enum logic [2:0] {
      S_CLEAR, S_SPAWN, S_MOVE, S_PLACE, S_NEXT, S_LOSE, S_WIN
   } state_t;

   localparam logic [3:0] INIT_W = 4'(INIT_WIDTH);

   state_t     state_reg, state_next;
   logic [7:0] val_reg, val_next;
   logic [2:0] row_reg, row_next;
   logic       strobe_reg, strobe_next;
   logic       clr_reg, clr_next;
   logic       over_reg, over_next;
   logic       win_reg, win_next;
   logic [3:0] placed_reg, placed_next;
   logic       dir_reg, dir_next;        // 0 = moving left (towards bit 7)
   logic [7:0] prev_mask_reg, prev_mask_next;
   logic [3:0] width_reg, width_next;

   logic [7:0] overlap;
   logic [3:0] overlap_count;
   logic [7:0] spawn_mask;

   assign overlap = val_reg & prev_mask_reg;

   // Low-aligned segment of width_reg cells
   for (genvar gi = 0; gi < 8; gi++) begin : g_spawn
      assign spawn_mask[gi] = (4'(gi) < width_reg);
   end

   // Number of cells that survive the commit
   always_comb begin
      overlap_count = '0;
      for (int i = 0; i < 8; i++) begin
         overlap_count = overlap_count + {3'b000, overlap[i]};
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S_CLEAR;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; btn beats a simultaneous tick in MOVE
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_CLEAR: state_next = S_SPAWN;
         S_SPAWN: state_next = S_MOVE;
         S_MOVE:  if (btn) state_next = S_PLACE;
         S_PLACE: begin
            if (overlap == 8'h00)      state_next = S_LOSE;
            else if (row_reg == 3'd7)  state_next = S_WIN;
            else                       state_next = S_NEXT;
         end
         S_NEXT:  state_next = S_SPAWN;
         S_LOSE:  if (btn) state_next = S_CLEAR;
         S_WIN:   if (btn) state_next = S_CLEAR;
         default: state_next = S_CLEAR;
      endcase
   end

   // Output and datapath next values; the pulse outputs default low
   always_comb begin
      val_next       = val_reg;
      row_next       = row_reg;
      strobe_next    = 1'b0;
      clr_next       = 1'b0;
      placed_next    = placed_reg;
      dir_next       = dir_reg;
      prev_mask_next = prev_mask_reg;
      width_next     = width_reg;
      over_next      = (state_next == S_LOSE);
      win_next       = (state_next == S_WIN);
      case (state_reg)
         S_CLEAR: begin
            clr_next       = 1'b1;
            row_next       = 3'd0;
            prev_mask_next = 8'hFF;
            width_next     = INIT_W;
            placed_next    = 4'd0;
         end
         S_SPAWN: begin
            val_next    = spawn_mask;
            dir_next    = 1'b0;
            strobe_next = 1'b1;
         end
         S_MOVE: begin
            if (update_tick && !btn) begin
               strobe_next = 1'b1;
               if (!dir_reg) begin
                  if (val_reg[7]) begin
                     dir_next = 1'b1;
                     val_next = val_reg >> 1;
                  end else begin
                     val_next = val_reg << 1;
                  end
               end else begin
                  if (val_reg[0]) begin
                     dir_next = 1'b0;
                     val_next = val_reg << 1;
                  end else begin
                     val_next = val_reg >> 1;
                  end
               end
            end
         end
         S_PLACE: begin
            strobe_next = 1'b1;
            if (overlap == 8'h00) begin
               val_next = 8'h00;
            end else begin
               val_next       = overlap;
               prev_mask_next = overlap;
               width_next     = overlap_count;
               placed_next    = placed_reg + 4'd1;
            end
         end
         S_NEXT:  row_next = row_reg + 3'd1;
         default: ;
      endcase
   end

   // Output and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         val_reg       <= 8'h00;
         row_reg       <= 3'd0;
         strobe_reg    <= 1'b0;
         clr_reg       <= 1'b0;
         over_reg      <= 1'b0;
         win_reg       <= 1'b0;
         placed_reg    <= 4'd0;
         dir_reg       <= 1'b0;
         prev_mask_reg <= 8'hFF;
         width_reg     <= INIT_W;
      end else begin
         val_reg       <= val_next;
         row_reg       <= row_next;
         strobe_reg    <= strobe_next;
         clr_reg       <= clr_next;
         over_reg      <= over_next;
         win_reg       <= win_next;
         placed_reg    <= placed_next;
         dir_reg       <= dir_next;
         prev_mask_reg <= prev_mask_next;
         width_reg     <= width_next;
      end
   end

   assign val          = val_reg;
   assign row_index    = row_reg;
   assign write_strobe = strobe_reg;
   assign clr_array    = clr_reg;
   assign game_over    = over_reg;
   assign win          = win_reg;
   assign rows_placed  = placed_reg;

endmodule

// File: tb/tb_stack_row_engine.sv
// Self-checking bench for stack_row_engine.
// Part 1 applies a table of directed transactions.
// Part 2 runs hand-written latency and reset corner sequences.
// Part 3 applies random transactions and checks them against a game-level model.
module tb_stack_row_engine;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn = 1'b0;
   logic       update_tick = 1'b0;
   logic [7:0] val;
   logic [2:0] row_index;
   logic       write_strobe;
   logic       clr_array;
   logic       game_over;
   logic       win;
   logic [3:0] rows_placed;

   stack_row_engine #(.INIT_WIDTH(3)) dut (
      .clk(clk), .reset(reset), .btn(btn), .update_tick(update_tick),
      .val(val), .row_index(row_index), .write_strobe(write_strobe),
      .clr_array(clr_array), .game_over(game_over), .win(win),
      .rows_placed(rows_placed)
   );

   always #5 clk = ~clk;

   typedef enum int {IDLE, TICK, BTN, BOTH, RST} op_t;

   typedef struct {
      op_t        op;
      int         n;      // write strobes seen in the transaction
      int         nclr;   // clr pulses seen
      logic [7:0] first;  // val at the first strobe
      logic [7:0] v;      // val at the end
      logic [2:0] row;
      logic       go;
      logic       wn;
      logic [3:0] rp;
   } vec_t;

   vec_t tbl[$];
   logic [7:0] tick_vals[11] = '{8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'h70,
                                 8'h38, 8'h1C, 8'h0E, 8'h07, 8'h0E};
   logic [7:0] lose_vals[4] = '{8'h0E, 8'h1C, 8'h38, 8'h70};

   int checks = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      checks++;
      if (write_strobe && clr_array) begin
         fails++;
         $display("FAIL strobe_clr_overlap: got both high expected at most one");
      end
   endtask

   // One operation cycle followed by four quiet cycles, which is enough for
   // any multi-state sequence to settle back into MOVE, LOSE or WIN
   task automatic run_txn(input op_t op, output int n, output int nclr, output logic [7:0] first);
      n = 0;
      nclr = 0;
      first = 8'h00;
      reset = (op == RST);
      btn = (op == BTN || op == BOTH);
      update_tick = (op == TICK || op == BOTH);
      for (int c = 0; c < 5; c++) begin
         step();
         reset = 1'b0;
         btn = 1'b0;
         update_tick = 1'b0;
         if (write_strobe) begin
            if (n == 0) first = val;
            n++;
         end
         if (clr_array) nclr++;
      end
   endtask

   task automatic compare_txn(input int idx, input op_t op, input int n, input int nclr,
                              input logic [7:0] first, input vec_t e);
      $display("txn %0d op=%s strobes=%0d clr=%0d val=%02h row=%0d go=%0b win=%0b placed=%0d",
               idx, op.name(), n, nclr, val, row_index, game_over, win, rows_placed);
      check("strobe_count", n, e.n);
      check("clr_count", nclr, e.nclr);
      if (e.n > 0) check("first_strobe_val", first, e.first);
      check("val", val, e.v);
      check("row_index", row_index, e.row);
      check("game_over", game_over, e.go);
      check("win", win, e.wn);
      check("rows_placed", rows_placed, e.rp);
   endtask

   task automatic add(input op_t op, input int n, input int nclr, input logic [7:0] first,
                      input logic [7:0] v, input logic [2:0] row, input logic go,
                      input logic wn, input logic [3:0] rp);
      vec_t e;
      e.op = op; e.n = n; e.nclr = nclr; e.first = first; e.v = v;
      e.row = row; e.go = go; e.wn = wn; e.rp = rp;
      tbl.push_back(e);
   endtask

   // ---------------- game-level reference model ----------------
   int         m_phase;      // 0 playing, 1 lost, 2 won
   int         m_row, m_width, m_pos, m_rp;
   bit         m_right;
   logic [7:0] m_prev, m_val;

   function automatic logic [7:0] seg(input int w, input int p);
      return 8'(((1 << w) - 1) << p);
   endfunction

   task automatic model_start();
      m_phase = 0; m_row = 0; m_width = 3; m_pos = 0; m_right = 1'b0;
      m_rp = 0; m_prev = 8'hFF; m_val = seg(3, 0);
   endtask

   task automatic model_apply(input op_t op, output vec_t e);
      logic [7:0] ov;
      e.op = op; e.n = 0; e.nclr = 0; e.first = 8'h00;
      if (op == RST) begin
         model_start();
         e.n = 1; e.nclr = 1; e.first = m_val;
      end else if (m_phase != 0) begin
         if (op == BTN || op == BOTH) begin
            model_start();
            e.n = 1; e.nclr = 1; e.first = m_val;
         end
      end else if (op == BTN || op == BOTH) begin
         ov = seg(m_width, m_pos) & m_prev;
         if (ov == 8'h00) begin
            m_phase = 1; m_val = 8'h00; e.n = 1; e.first = 8'h00;
         end else begin
            m_rp++; m_prev = ov; m_width = $countones(ov); e.first = ov;
            if (m_row == 7) begin
               m_phase = 2; m_val = ov; e.n = 1;
            end else begin
               m_row++; m_pos = 0; m_right = 1'b0;
               m_val = seg(m_width, 0); e.n = 2;
            end
         end
      end else if (op == TICK) begin
         if (!m_right) begin
            if (m_pos + m_width == 8) begin m_right = 1'b1; m_pos--; end
            else m_pos++;
         end else begin
            if (m_pos == 0) begin m_right = 1'b0; m_pos++; end
            else m_pos--;
         end
         m_val = seg(m_width, m_pos);
         e.n = 1; e.first = m_val;
      end
      e.v = m_val; e.row = 3'(m_row); e.go = (m_phase == 1);
      e.wn = (m_phase == 2); e.rp = 4'(m_rp);
   endtask

   initial begin
      int n, nclr, r;
      logic [7:0] first;
      vec_t e;
      op_t op;

      // ---------------- directed table ----------------
      add(RST, 1, 1, 8'h07, 8'h07, 3'd0, 1'b0, 1'b0, 4'd0);
      for (int i = 0; i < 11; i++) add(TICK, 1, 0, tick_vals[i], tick_vals[i], 3'd0, 1'b0, 1'b0, 4'd0);
      add(RST, 1, 1, 8'h07, 8'h07, 3'd0, 1'b0, 1'b0, 4'd0);
      add(BTN, 2, 0, 8'h07, 8'h07, 3'd1, 1'b0, 1'b0, 4'd1);
      add(TICK, 1, 0, 8'h0E, 8'h0E, 3'd1, 1'b0, 1'b0, 4'd1);
      add(BTN, 2, 0, 8'h06, 8'h03, 3'd2, 1'b0, 1'b0, 4'd2);
      add(RST, 1, 1, 8'h07, 8'h07, 3'd0, 1'b0, 1'b0, 4'd0);
      add(BTN, 2, 0, 8'h07, 8'h07, 3'd1, 1'b0, 1'b0, 4'd1);
      for (int i = 0; i < 4; i++) add(TICK, 1, 0, lose_vals[i], lose_vals[i], 3'd1, 1'b0, 1'b0, 4'd1);
      add(BTN, 1, 0, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0, 4'd1);
      add(TICK, 0, 0, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0, 4'd1);
      add(BTN, 1, 1, 8'h07, 8'h07, 3'd0, 1'b0, 1'b0, 4'd0);
      for (int k = 0; k < 7; k++) add(BTN, 2, 0, 8'h07, 8'h07, 3'(k + 1), 1'b0, 1'b0, 4'(k + 1));
      add(BTN, 1, 0, 8'h07, 8'h07, 3'd7, 1'b0, 1'b1, 4'd8);
      add(TICK, 0, 0, 8'h00, 8'h07, 3'd7, 1'b0, 1'b1, 4'd8);
      add(BTN, 1, 1, 8'h07, 8'h07, 3'd0, 1'b0, 1'b0, 4'd0);
      add(TICK, 1, 0, 8'h0E, 8'h0E, 3'd0, 1'b0, 1'b0, 4'd0);
      add(BOTH, 2, 0, 8'h0E, 8'h07, 3'd1, 1'b0, 1'b0, 4'd1);

      reset = 1'b1;
      step();
      check("reset_val", val, 8'h00);
      check("reset_strobe", write_strobe, 1'b0);
      check("reset_clr", clr_array, 1'b0);

      for (int i = 0; i < tbl.size(); i++) begin
         run_txn(tbl[i].op, n, nclr, first);
         compare_txn(i, tbl[i].op, n, nclr, first, tbl[i]);
      end

      // ---------------- latency sequence (row 1, val 07, prev 0E) ----------------
      update_tick = 1'b1;
      step();
      update_tick = 1'b0;
      check("tick_latency_strobe", write_strobe, 1'b1);
      check("tick_latency_val", val, 8'h0E);
      step();
      check("tick_single_strobe", write_strobe, 1'b0);
      btn = 1'b1;
      step();
      btn = 1'b0;
      check("place_cycle_no_strobe", write_strobe, 1'b0);
      step();
      check("commit_strobe", write_strobe, 1'b1);
      check("commit_val", val, 8'h0E);
      check("commit_row", row_index, 3'd1);
      step();
      check("next_no_strobe", write_strobe, 1'b0);
      check("next_row", row_index, 3'd2);
      step();
      check("spawn_strobe", write_strobe, 1'b1);
      check("spawn_val", val, 8'h07);
      check("spawn_placed", rows_placed, 4'd2);

      // ---------------- reset during MOVE on row 4 ----------------
      run_txn(BTN, n, nclr, first);
      run_txn(BTN, n, nclr, first);
      run_txn(TICK, n, nclr, first);
      check("pre_reset_row", row_index, 3'd4);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_reset_val", val, 8'h00);
      check("mid_reset_row", row_index, 3'd0);
      check("mid_reset_strobe", write_strobe, 1'b0);
      check("mid_reset_clr", clr_array, 1'b0);
      check("mid_reset_go", game_over, 1'b0);
      check("mid_reset_win", win, 1'b0);
      check("mid_reset_placed", rows_placed, 4'd0);
      step();
      check("post_reset_clr", clr_array, 1'b1);
      check("post_reset_no_strobe", write_strobe, 1'b0);
      step();
      check("post_reset_clr_drop", clr_array, 1'b0);
      check("post_reset_spawn", write_strobe, 1'b1);
      check("post_reset_val", val, 8'h07);

      // ---------------- random transactions against the model ----------------
      run_txn(RST, n, nclr, first);
      model_start();
      for (int i = 0; i < 200; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 2)       op = RST;
         else if (r < 10) op = IDLE;
         else if (r < 68) op = TICK;
         else if (r < 93) op = BTN;
         else             op = BOTH;
         model_apply(op, e);
         run_txn(op, n, nclr, first);
         compare_txn(1000 + i, op, n, nclr, first, e);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
